// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a valid/ready handshake and precise ALU-overflow exception hand-off to CP0.
// Optional forwarding outputs are enabled by defining EXMEM_FWD_EN.
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              exValid,
    output logic              exReady,
    input  logic [DATA_W-1:0] aluResult,
    input  logic              aluException,
    input  logic [DATA_W-1:0] storeData,
    input  logic [REG_W-1:0]  destReg,
    input  logic              regWriteIn,
    input  logic              memReadIn,
    input  logic              memWriteIn,
    input  logic [DATA_W-1:0] pcIn,
    input  logic              flush,
    output logic              memValid,
    input  logic              memReady,
    output logic [DATA_W-1:0] memAluOut,
    output logic [DATA_W-1:0] memStoreData,
    output logic [REG_W-1:0]  memDestReg,
    output logic              memRegWrite,
    output logic              memRead,
    output logic              memWrite,
    output logic [DATA_W-1:0] memPc,
    output logic              excReq,
    output logic [DATA_W-1:0] excPc,
`ifdef EXMEM_FWD_EN
    output logic              fwdValid,
    output logic [REG_W-1:0]  fwdReg,
    output logic [DATA_W-1:0] fwdData,
`endif
    input  logic              excAck
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        EXC_WAIT = 1'b1
    } state_t;

    state_t state_r;
    state_t state_s;
    logic   accept_s;
    logic   load_s;
    logic   exc_s;
    logic   mem_valid_s;
    logic   exc_req_s;

    assign exReady  = (state_r == RUN) && (!memValid || memReady);
    assign accept_s = exValid && exReady && !flush;

    // Next-state, entry load and exception raise/clear decisions
    always_comb begin
        state_s     = state_r;
        exc_req_s   = excReq;
        load_s      = 1'b0;
        exc_s       = 1'b0;
        mem_valid_s = memValid;
        case (state_r)
            RUN: begin
                if (accept_s && aluException) begin
                    exc_s     = 1'b1;
                    exc_req_s = 1'b1;
                    state_s   = EXC_WAIT;
                end else if (accept_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            EXC_WAIT: begin
                if (excAck) begin
                    exc_req_s = 1'b0;
                    state_s   = RUN;
                end else begin
                    exc_req_s = excReq;
                end
            end
            default: begin
                state_s   = RUN;
                exc_req_s = 1'b0;
            end
        endcase
        // A faulting instruction never becomes an entry; the older entry may still drain
        if (load_s) begin
            mem_valid_s = 1'b1;
        end else if (memValid && memReady) begin
            mem_valid_s = 1'b0;
        end else begin
            mem_valid_s = memValid;
        end
    end

    // State, handshake and payload registers
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_r      <= RUN;
            memValid     <= 1'b0;
            memAluOut    <= {DATA_W{1'b0}};
            memStoreData <= {DATA_W{1'b0}};
            memDestReg   <= {REG_W{1'b0}};
            memRegWrite  <= 1'b0;
            memRead      <= 1'b0;
            memWrite     <= 1'b0;
            memPc        <= {DATA_W{1'b0}};
            excReq       <= 1'b0;
            excPc        <= {DATA_W{1'b0}};
        end else begin
            state_r  <= state_s;
            memValid <= mem_valid_s;
            excReq   <= exc_req_s;
            if (load_s) begin
                memAluOut    <= aluResult;
                memStoreData <= storeData;
                memDestReg   <= destReg;
                memRegWrite  <= regWriteIn;
                memRead      <= memReadIn;
                memWrite     <= memWriteIn;
                memPc        <= pcIn;
            end
            if (exc_s) begin
                excPc <= pcIn;
            end
        end
    end

`ifdef EXMEM_FWD_EN
    // Loads are excluded: their data is not known until MEM completes
    assign fwdValid = memValid && memRegWrite && !memRead && (memDestReg != {REG_W{1'b0}});
    assign fwdReg   = memDestReg;
    assign fwdData  = memAluOut;
`endif

endmodule
